register_file_mp: RTL and testbench

- Parametrised multi-read-port register file; next generation of the fixed 32x32 two-read/one-write register file used by the processor datapath.
- Generalised in data width, depth and read-port count; one write port; registered read outputs with per-port enable.
- Adds same-cycle write-to-read bypass and a defined READ+WRITE overlap.
- Sits between the decode stage (addresses) and the ALU operand muxes.

---
 rtl/register_file_mp_pkg.sv | 12 +
 rtl/register_file_mp_rf_read_port.sv | 57 +++++
 rtl/register_file_mp.sv | 66 ++++++
 tb/tb_register_file_mp.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared sizing defaults and derived index limits for the multi-read-port register file.
package register_file_mp_pkg;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_NUM_RD     = 2;

   localparam int RF_DATA_MSB   = RF_DATA_WIDTH - 1;
   localparam int RF_ADDR_MSB   = RF_ADDR_WIDTH - 1;
   localparam int RF_RD_MSB     = RF_NUM_RD - 1;

endpackage

// File: rtl/register_file_mp_rf_read_port.sv
// One registered read lane: write-first bypass, optional R0 zero gating (RF_R0_ZERO_EN),
// enable-gated output register with asynchronous clear.
module rf_read_port
   import register_file_mp_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] arr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wr_hit
);

   logic                  hit;
   logic                  r0_sel;
   logic [DATA_WIDTH-1:0] rd_data_reg, rd_data_next;
   logic                  wr_hit_reg, wr_hit_next;

   assign hit = wr_en && (rd_addr == wr_addr);

`ifdef RF_R0_ZERO_EN
   assign r0_sel = (rd_addr == '0);
`else
   assign r0_sel = 1'b0;
`endif

   // Bypass gives the freshly written value; R0 gating overrides it.
   always_comb begin
      rd_data_next = hit ? wr_data : arr_data;
      wr_hit_next  = hit;
      if (r0_sel) begin
         rd_data_next = '0;
         wr_hit_next  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_reg <= '0;
         wr_hit_reg  <= 1'b0;
      end else if (rd_en) begin
         rd_data_reg <= rd_data_next;
         wr_hit_reg  <= wr_hit_next;
      end
   end

   assign rd_data = rd_data_reg;
   assign wr_hit  = wr_hit_reg;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised register file: one write port, NUM_RD registered read ports with bypass.
// Optional feature macro: RF_R0_ZERO_EN (entry 0 hardwired to zero).
module register_file_mp
   import register_file_mp_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int NUM_RD     = RF_NUM_RD
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_RD-1:0]            READ,
   input  logic                         WRITE,
   input  logic [ADDR_WIDTH-1:0]        ADDR_W,
   input  logic [DATA_WIDTH-1:0]        DATA_W,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] ADDR_R,
   output logic [NUM_RD*DATA_WIDTH-1:0] DATA_R,
   output logic [NUM_RD-1:0]            WR_HIT
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
   logic                  wr_ok;

`ifdef RF_R0_ZERO_EN
   assign wr_ok = WRITE && (ADDR_W != '0);
`else
   assign wr_ok = WRITE;
`endif

   // Storage must clear on reset, so it is built from flops rather than block RAM.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_reg[ADDR_W] <= DATA_W;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] rd_addr;
         assign rd_addr = ADDR_R[gi*ADDR_WIDTH +: ADDR_WIDTH];

         rf_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_port (
            .clk      (CLK),
            .rst_n    (RST),
            .rd_en    (READ[gi]),
            .rd_addr  (rd_addr),
            .wr_en    (WRITE),
            .wr_addr  (ADDR_W),
            .wr_data  (DATA_W),
            .arr_data (mem_reg[rd_addr]),
            .rd_data  (DATA_R[gi*DATA_WIDTH +: DATA_WIDTH]),
            .wr_hit   (WR_HIT[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default 32x32x2 build plus a 16-bit, 8-entry, 4-port build.
module tb_register_file_mp;

   logic        CLK;
   logic        RST;
   logic [1:0]  READ;
   logic        WRITE;
   logic [4:0]  ADDR_W;
   logic [31:0] DATA_W;
   logic [9:0]  ADDR_R;
   logic [63:0] DATA_R;
   logic [1:0]  WR_HIT;

   logic [3:0]  READ2;
   logic        WRITE2;
   logic [2:0]  ADDR_W2;
   logic [15:0] DATA_W2;
   logic [11:0] ADDR_R2;
   logic [63:0] DATA_R2;
   logic [3:0]  WR_HIT2;

   int vectors = 0;
   int miscompares = 0;

   register_file_mp dut (
      .CLK    (CLK),
      .RST    (RST),
      .READ   (READ),
      .WRITE  (WRITE),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .ADDR_R (ADDR_R),
      .DATA_R (DATA_R),
      .WR_HIT (WR_HIT)
   );

   register_file_mp #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (3),
      .NUM_RD     (4)
   ) dut_small (
      .CLK    (CLK),
      .RST    (RST),
      .READ   (READ2),
      .WRITE  (WRITE2),
      .ADDR_W (ADDR_W2),
      .DATA_W (DATA_W2),
      .ADDR_R (ADDR_R2),
      .DATA_R (DATA_R2),
      .WR_HIT (WR_HIT2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      RST = 1'b0; READ = '0; WRITE = 1'b0; ADDR_W = '0; DATA_W = '0; ADDR_R = '0;
      READ2 = '0; WRITE2 = 1'b0; ADDR_W2 = '0; DATA_W2 = '0; ADDR_R2 = '0;

      // Reset held: writes and reads are ignored, outputs stay zero
      WRITE = 1'b1; ADDR_W = 5'd5; DATA_W = 32'h0000_0055;
      READ = 2'b11; ADDR_R = {5'd5, 5'd5};
      repeat (3) tick();
      check("reset_data", DATA_R, 64'h0);
      check("reset_hit", {62'h0, WR_HIT}, 64'h0);
      check("reset_small_data", DATA_R2, 64'h0);

      RST = 1'b1; WRITE = 1'b0;
      tick();
      check("post_reset_addr5", DATA_R, 64'h0);
      check("post_reset_hit", {62'h0, WR_HIT}, 64'h0);

      // Fill mem[i] = i, then read i on port 0 and 31-i on port 1
      READ = 2'b00;
      for (int i = 0; i < 32; i++) begin
         WRITE = 1'b1; ADDR_W = 5'(i); DATA_W = 32'(i);
         tick();
      end
      WRITE = 1'b0;
      for (int i = 0; i < 32; i++) begin
         READ = 2'b11; ADDR_R = {5'(31 - i), 5'(i)};
         tick();
         check($sformatf("fill_rd_%0d", i), DATA_R, {32'(31 - i), 32'(i)});
      end
      check("fill_hit", {62'h0, WR_HIT}, 64'h0);

      // Bypass on both ports to the same address
      READ = 2'b00; WRITE = 1'b1; ADDR_W = 5'd7; DATA_W = 32'h1111_1111;
      tick();
      READ = 2'b11; ADDR_R = {5'd7, 5'd7}; DATA_W = 32'hDEAD_BEEF;
      tick();
      check("bypass_data", DATA_R, {2{32'hDEAD_BEEF}});
      check("bypass_hit", {62'h0, WR_HIT}, 64'h3);
      WRITE = 1'b0; ADDR_R = {5'd9, 5'd9};
      tick();
      check("after_bypass_data", DATA_R, {2{32'h0000_0009}});
      check("after_bypass_hit", {62'h0, WR_HIT}, 64'h0);

      // Only port 1 matches the write address
      WRITE = 1'b1; ADDR_W = 5'd3; DATA_W = 32'h3333_0000; ADDR_R = {5'd3, 5'd7};
      tick();
      check("partial_bypass_data", DATA_R, {32'h3333_0000, 32'hDEAD_BEEF});
      check("partial_bypass_hit", {62'h0, WR_HIT}, 64'h2);

      // Hold: disabled ports keep data and flag while address and array change
      READ = 2'b00; WRITE = 1'b1; ADDR_W = 5'd20; DATA_W = 32'h0000_ABCD;
      tick();
      WRITE = 1'b0; READ = 2'b10; ADDR_R = {5'd20, 5'd9};
      tick();
      check("hold_capture", DATA_R, {32'h0000_ABCD, 32'hDEAD_BEEF});
      check("hold_capture_hit", {62'h0, WR_HIT}, 64'h0);
      READ = 2'b00;
      for (int k = 0; k < 3; k++) begin
         ADDR_R = {5'd21, 5'd21}; WRITE = 1'b1; ADDR_W = 5'd21; DATA_W = 32'h1000 + 32'(k);
         tick();
         check($sformatf("hold_cycle_%0d", k), DATA_R, {32'h0000_ABCD, 32'hDEAD_BEEF});
         check($sformatf("hold_hit_%0d", k), {62'h0, WR_HIT}, 64'h0);
      end

      // Asynchronous reset in the middle of back-to-back writes
      READ = 2'b11; ADDR_R = {5'd11, 5'd10}; WRITE = 1'b1; ADDR_W = 5'd10; DATA_W = 32'h0000_1010;
      tick();
      ADDR_W = 5'd11; DATA_W = 32'h0000_1111;
      tick();
      check("pre_reset_data", DATA_R, {32'h0000_1111, 32'h0000_1010});
      check("pre_reset_hit", {62'h0, WR_HIT}, 64'h2);
      ADDR_W = 5'd12; DATA_W = 32'h0000_1212;
      #2 RST = 1'b0;
      #1;
      check("async_reset_data", DATA_R, 64'h0);
      check("async_reset_hit", {62'h0, WR_HIT}, 64'h0);
      tick();
      RST = 1'b1; WRITE = 1'b0; ADDR_R = {5'd11, 5'd10};
      tick();
      check("cleared_10_11", DATA_R, 64'h0);
      ADDR_R = {5'd12, 5'd7};
      tick();
      check("cleared_12_7", DATA_R, 64'h0);
      ADDR_R = {5'd31, 5'd20};
      tick();
      check("cleared_31_20", DATA_R, 64'h0);

      // Narrow, shallow, four-port build
      WRITE2 = 1'b1; ADDR_W2 = 3'd7; DATA_W2 = 16'hA5A5;
      tick();
      WRITE2 = 1'b0; READ2 = 4'b1111; ADDR_R2 = {4{3'd7}};
      tick();
      check("small_all_addr7", DATA_R2, {4{16'hA5A5}});
      check("small_hit_none", {60'h0, WR_HIT2}, 64'h0);
      READ2 = 4'b0000; WRITE2 = 1'b1; ADDR_W2 = 3'd2; DATA_W2 = 16'h0202;
      tick();
      READ2 = 4'b1111; ADDR_W2 = 3'd5; DATA_W2 = 16'h5555;
      ADDR_R2 = {3'd5, 3'd2, 3'd7, 3'd0};
      tick();
      check("small_lanes", DATA_R2, {16'h5555, 16'h0202, 16'hA5A5, 16'h0000});
      check("small_hit_lane3", {60'h0, WR_HIT2}, 64'h8);
      check("small_no_cross_talk", DATA_R, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
